mem_access_unit: RTL
====================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: wordsize, 16, data word width in bits.
REQ-002 Parameter: addrsize, 8, byte-address width in bits.
REQ-003 Parameter: waitstates, 0, extra ACCESS cycles per transaction, range 0..15.
REQ-004 Port: clk  input  1  clock; one clock, all logic on posedge clk.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: req  input  1  datapath request strobe.
REQ-007 Port: we  input  1  1 = write, 0 = read.
REQ-008 Port: addr  input  addrsize  byte address from datapath bus a.
REQ-009 Port: wdata  input  wordsize  write data from datapath bus b.
REQ-010 Port: rdata  output  wordsize  registered read result.
REQ-011 Port: ack  output  1  one-cycle completion pulse.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: err  output  1  misalignment flag, valid only with ack.
REQ-014 Port: mem_addr  output  addrsize  byte address to the memory addr input.
REQ-015 Port: mem_rw  output  1  to the memory rw input; 1 writes on the next posedge.
REQ-016 Port: mem_wdata  output  wordsize  to the memory data_in input.
REQ-017 Port: mem_rdata  input  wordsize  from the memory data_out input; combinational, high-Z while mem_rw = 1.

Function
REQ-018 The FSM SHALL have the states IDLE, ACCESS and DONE, held in a registered state variable.
REQ-019 In IDLE with req = 1, the block SHALL latch addr, we and wdata into mem_addr, an internal we register and mem_wdata, then go to ACCESS.
REQ-020 In IDLE with req = 0, the block SHALL stay in IDLE.
REQ-021 ACCESS SHALL last exactly waitstates+1 cycles, counted by a 4-bit down-counter loaded with waitstates on entry.
REQ-022 mem_rw SHALL be 1 only during the final ACCESS cycle of a write, giving exactly one memory write edge per write.
REQ-023 mem_rw SHALL be 0 in all other cycles.
REQ-024 On a read, rdata SHALL capture mem_rdata at the end of the final ACCESS cycle.
REQ-025 rdata SHALL hold its value until the next read completes; writes and errors SHALL leave rdata unchanged.
REQ-026 From ACCESS, the FSM SHALL go to DONE; in DONE, ack SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-027 Latency: with req sampled high in cycle 0, ack SHALL be high in cycle waitstates+2.
REQ-028 req SHALL be ignored in ACCESS and DONE.
REQ-029 If req is held high through DONE, a new transaction SHALL start in the following IDLE cycle, giving a throughput of one transaction per waitstates+3 cycles.
REQ-030 mem_addr and mem_wdata SHALL stay stable from the cycle after acceptance through DONE.
REQ-031 err SHALL be 0 whenever ack = 0.

Reset
REQ-032 With rst = 1 at a posedge: state = IDLE; rdata, mem_addr, mem_wdata and the counter = 0; ack, err, busy and mem_rw = 0.
REQ-033 Reset asserted mid-transaction SHALL abort it with no ack and no memory write, and mem_rw SHALL be 0 from the next cycle.
REQ-034 rst SHALL take priority over req in the same cycle.

Configuration
REQ-035 Macro MISALIGN_CHECK_EN, defined: an accepted request with addr[0] = 1 SHALL skip ACCESS, go straight to DONE with ack = 1 and err = 1 in cycle 1, leave mem_rw = 0 and leave rdata unchanged.
REQ-036 MISALIGN_CHECK_EN undefined: err SHALL be tied to 0, addr[0] SHALL be ignored (the memory's word shift applies), and every request SHALL follow the normal path.

Verification
REQ-037 waitstates = 0: reset, then write req with addr = 0x10 and wdata = 0xBEEF -> mem_rw = 1 in cycle 1 only, ack in cycle 2, err = 0.
REQ-038 Read of addr = 0x10 after REQ-037 -> rdata = 0xBEEF with ack in cycle 2, mem_rw = 0 throughout.
REQ-039 waitstates = 2: read addr = 0x04 -> busy high in cycles 1..4, ack in cycle 4; req pulses in cycles 1..3 are ignored.
REQ-040 rst asserted in the ACCESS cycle of a write to 0x20 -> no ack; a later read of 0x20 returns the prior contents.
REQ-041 MISALIGN_CHECK_EN defined: write with addr = 0x21 -> ack = 1 and err = 1 in cycle 1, mem_rw never 1, memory unchanged.
REQ-042 req held high for 12 cycles, reads, waitstates = 0 -> ack in cycles 2, 5, 8 and 11.

Source files
------------

// File: rtl/mem_access_unit.sv
// Datapath-to-memory access sequencer: IDLE -> ACCESS (waitstates+1 cycles) -> DONE.
// Optional build macro MISALIGN_CHECK_EN flags odd byte addresses with err instead of accessing memory.
module mem_access_unit #(
  parameter int wordsize   = 16,
  parameter int addrsize   = 8,
  parameter int waitstates = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [addrsize-1:0] addr,
  input  logic [wordsize-1:0] wdata,
  output logic [wordsize-1:0] rdata,
  output logic                ack,
  output logic                busy,
  output logic                err,
  output logic [addrsize-1:0] mem_addr,
  output logic                mem_rw,
  output logic [wordsize-1:0] mem_wdata,
  input  logic [wordsize-1:0] mem_rdata,
  output logic [1:0]          state_dbg
);

  // Handshake: req is sampled only in IDLE; the request is complete when ack pulses
  // for one cycle in DONE, and busy stays high from acceptance until the return to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(waitstates);

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [addrsize-1:0]   mem_addr_q, mem_addr_d;
  logic [wordsize-1:0]   mem_wdata_q, mem_wdata_d;
  logic [wordsize-1:0]   rdata_q, rdata_d;
  logic                  mem_rw_q, mem_rw_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  misalign;

  always_comb begin
`ifdef MISALIGN_CHECK_EN
    misalign = addr[0];
`else
    misalign = 1'b0;
`endif
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    mem_rw_d    = 1'b0;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          mem_addr_d  = addr;
          mem_wdata_d = wdata;
          we_d        = we;
          cnt_d       = WAIT_LOAD;
          if (misalign) begin
            state_d = DONE;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d  = ACCESS;
            // mem_rw is registered, so it is raised one cycle ahead of the final ACCESS cycle.
            mem_rw_d = we && (WAIT_LOAD == 4'd0);
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          ack_d   = 1'b1;
          if (!we_q) rdata_d = mem_rdata;
        end else begin
          cnt_d    = cnt_q - 4'd1;
          mem_rw_d = we_q && (cnt_q == 4'd1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      mem_rw_q    <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      mem_rw_q    <= mem_rw_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
    end
  end

  // A reset landing on the write cycle must suppress that memory write edge.
  assign mem_rw    = mem_rw_q & ~rst;
  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign state_dbg = state_q;

endmodule
